multi_upload: RTL and testbench
===============================

MULTI_UPLOAD -- requirements
Module: multi_upload

Interface
REQ-001 Parameter CH_NUM, default 2, number of capture channels (1..8).
REQ-002 Parameter FIFO_DEPTH, default 16, bytes per channel FIFO (power of two, 4..256).
REQ-003 Parameter BAUD_DIV, default 208, clk_24m cycles per UART bit (>=4).
REQ-004 clk_24m  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ch_udi  input  CH_NUM  serial data per channel; asynchronous to clk_24m.
REQ-007 ch_nvm  input  CH_NUM  frame gate per channel; high = bits valid; asynchronous.
REQ-008 ch_dclk  input  CH_NUM  remote data clock per channel; asynchronous.
REQ-009 ch_en  input  CH_NUM  channel capture enable, synchronous to clk_24m.
REQ-010 ovf_clr  input  1  single-cycle pulse; clears all overflow flags.
REQ-011 tx  output  1  UART 8N1 uplink, idle high.
REQ-012 busy  output  1  high while a UART frame (tag or data) is in flight.
REQ-013 ch_empty  output  CH_NUM  per-channel FIFO empty.
REQ-014 ch_ovf  output  CH_NUM  per-channel sticky overflow flag.

Function
REQ-015 ch_udi, ch_nvm, ch_dclk each pass a 2-flop synchroniser; the DCLK rising edge is detected from the synchronised value (3rd flop compare).
REQ-016 On a detected DCLK rise with synced nvm=1 and ch_en=1, shift synced udi into the channel shift register MSB-first and increment a 3-bit bit counter.
REQ-017 On the 8th bit, push the assembled byte into the channel FIFO in the same cycle the counter wraps to 0.
REQ-018 Synced nvm=0 or ch_en=0 resets the bit counter; any partial byte is discarded; FIFO contents are kept and still drained.
REQ-019 Push to a full FIFO: byte dropped, FIFO unchanged, ch_ovf[n] set.
REQ-020 ovf_clr clears all ch_ovf; same-cycle set and clear on a channel: set wins.
REQ-021 Simultaneous push and pop on one FIFO: both performed, count unchanged; push into a full FIFO with same-cycle pop is accepted.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-023 Arbiter: when TX state is IDLE and any FIFO non-empty, pop from the first non-empty channel searching round-robin starting at (last served + 1) mod CH_NUM; after reset last served = CH_NUM-1 (channel 0 first).
REQ-024 TX states: IDLE, TAG, START, DATA, STOP; each bit held exactly BAUD_DIV cycles; data sent LSB-first; stop bit high.
REQ-025 Pop-to-start-bit latency: tx falls one clk_24m cycle after the pop cycle.
REQ-026 busy rises in the cycle after the pop and falls when STOP completes; the next pop may occur in the cycle busy falls (back-to-back frames, no idle gap).
REQ-027 A frame in flight always completes regardless of ch_en changes.

Reset
REQ-028 rst asynchronously forces: tx=1, busy=0, ch_empty=all 1, ch_ovf=0, all FIFOs empty, bit counters 0, shift registers 0, synchronisers 0, TX state IDLE, baud counter 0.
REQ-029 rst asserted mid-frame aborts the frame; tx is high immediately; no partial frame resumes after release.

Configuration
REQ-030 Macro MULTI_UPLOAD_TAG_EN defined: each popped data byte is preceded by a full 8N1 tag frame of value 8'hA0 | channel index, entered via TAG state; busy stays high across tag and data frames.
REQ-031 Macro MULTI_UPLOAD_TAG_EN undefined: TAG state and tag logic absent; only data frames are sent.

Verification
REQ-032 Ch0, nvm=1, en=1, DCLK bits 1,0,1,0,0,1,0,1 -> ch_empty[0] falls; tx sends start,1,0,1,0,0,1,0,1,stop (0xA5 LSB-first), each bit 208 cycles.
REQ-033 16 bytes into ch1 with tx held busy, then a 17th -> ch_ovf[1]=1, 17th byte dropped; ovf_clr pulse -> ch_ovf[1]=0; 16 bytes drained in order.
REQ-034 Ch0 and ch1 each hold 2 bytes (0x11,0x12 / 0x21,0x22) -> tx order 0x11,0x21,0x12,0x22 back-to-back, busy continuous.
REQ-035 nvm dropped after 5 bits, then 8 bits 0x3C -> only 0x3C captured.
REQ-036 rst pulsed during DATA bit 3 -> tx=1 same cycle, busy=0, all FIFOs empty; no further frames.
REQ-037 With MULTI_UPLOAD_TAG_EN, byte 0x5A on ch1 -> frames 0xA1 then 0x5A, 20*BAUD_DIV cycles total busy.

Source files
------------

// File: rtl/multi_upload_if.sv
// Capture-side inputs and UART-side status for multi_upload, seen as one bundle.
interface multi_upload_if #(
  parameter int CH_NUM = 2
);
  logic [CH_NUM-1:0] ch_udi;
  logic [CH_NUM-1:0] ch_nvm;
  logic [CH_NUM-1:0] ch_dclk;
  logic [CH_NUM-1:0] ch_en;
  logic              ovf_clr;
  logic              tx;
  logic              busy;
  logic [CH_NUM-1:0] ch_empty;
  logic [CH_NUM-1:0] ch_ovf;

  modport master (
    output ch_udi, ch_nvm, ch_dclk, ch_en, ovf_clr,
    input  tx, busy, ch_empty, ch_ovf
  );

  modport slave (
    input  ch_udi, ch_nvm, ch_dclk, ch_en, ovf_clr,
    output tx, busy, ch_empty, ch_ovf
  );
endinterface

// File: rtl/multi_upload.sv
// Per-channel serial capture into byte FIFOs, drained round-robin onto one 8N1 UART (start bit 1 cycle after pop).
// Full FIFO drops the byte and sets ch_ovf; MULTI_UPLOAD_TAG_EN prefixes every data frame with a tag frame 0xA0|channel.
module multi_upload #(
  parameter int CH_NUM     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 208
) (
  input logic           clk_24m,
  input logic           rst,
  multi_upload_if.slave up_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BW = $clog2(BAUD_DIV);

`ifdef MULTI_UPLOAD_TAG_EN
  typedef enum logic [2:0] {S_IDLE, S_TAG, S_START, S_DATA, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [CH_NUM-1:0] udi_s1_q, udi_s2_q, nvm_s1_q, nvm_s2_q;
  logic [CH_NUM-1:0] dclk_s1_q, dclk_s2_q, dclk_s3_q;
  logic [7:0]        shift_q [CH_NUM];
  logic [7:0]        shift_d [CH_NUM];
  logic [2:0]        bcnt_q  [CH_NUM];
  logic [2:0]        bcnt_d  [CH_NUM];
  logic [AW-1:0]     wr_q    [CH_NUM];
  logic [AW-1:0]     wr_d    [CH_NUM];
  logic [AW-1:0]     rd_q    [CH_NUM];
  logic [AW-1:0]     rd_d    [CH_NUM];
  logic [CW-1:0]     cnt_q   [CH_NUM];
  logic [CW-1:0]     cnt_d   [CH_NUM];
  logic [7:0]        mem_q   [CH_NUM][FIFO_DEPTH];
  logic [CH_NUM-1:0] ovf_q, ovf_d, push, wr_en, pop_ch, nonempty;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d, pop_byte;
  logic [SW-1:0] last_q, last_d, sel;
  logic          tx_q, tx_d, found, pop_vld, baud_last;
`ifdef MULTI_UPLOAD_TAG_EN
  logic [SW-1:0] tch_q, tch_d;
  logic [7:0]    tag_w;
  logic [2:0]    tag_idx;
`endif

  // Capture and FIFO bookkeeping; a pop into a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    for (int n = 0; n < CH_NUM; n++) begin
      shift_d[n] = shift_q[n];
      bcnt_d[n]  = bcnt_q[n];
      push[n]    = 1'b0;
      if (!nvm_s2_q[n] || !up_if.ch_en[n]) begin
        shift_d[n] = 8'd0;
        bcnt_d[n]  = 3'd0;
      end else if (dclk_s2_q[n] && !dclk_s3_q[n]) begin
        shift_d[n] = {shift_q[n][6:0], udi_s2_q[n]};
        bcnt_d[n]  = bcnt_q[n] + 3'd1;
        push[n]    = (bcnt_q[n] == 3'd7);
      end
      nonempty[n] = (cnt_q[n] != '0);
      pop_ch[n]   = pop_vld && (sel == SW'(n));
      wr_en[n]    = push[n] && ((cnt_q[n] != CW'(FIFO_DEPTH)) || pop_ch[n]);
      ovf_d[n]    = (ovf_q[n] && !up_if.ovf_clr) ||
                    (push[n] && (cnt_q[n] == CW'(FIFO_DEPTH)) && !pop_ch[n]);
      wr_d[n]     = wr_q[n] + AW'(wr_en[n]);
      rd_d[n]     = rd_q[n] + AW'(pop_ch[n]);
      cnt_d[n]    = cnt_q[n] + CW'(wr_en[n]) - CW'(pop_ch[n]);
    end
  end

  always_comb begin
    found    = 1'b0;
    sel      = last_q;
    pop_byte = 8'd0;
    for (int k = 1; k <= CH_NUM; k++) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (!found && nonempty[n] && (((int'(last_q) + k) % CH_NUM) == n)) begin
          found = 1'b1;
          sel   = SW'(n);
        end
      end
    end
    for (int n = 0; n < CH_NUM; n++) begin
      if (sel == SW'(n)) pop_byte = mem_q[n][rd_q[n]];
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    last_d    = last_q;
    baud_last = (baud_q == BW'(BAUD_DIV - 1));
    if (state_q != S_IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);
    if (baud_last) begin
      case (state_q)
`ifdef MULTI_UPLOAD_TAG_EN
        S_TAG: if (bit_q == 4'd9) begin
          state_d = S_START;
          bit_d   = 4'd0;
        end else bit_d = bit_q + 4'd1;
`endif
        S_START: begin
          state_d = S_DATA;
          bit_d   = 4'd0;
        end
        S_DATA:  if (bit_q == 4'd7) state_d = S_STOP; else bit_d = bit_q + 4'd1;
        S_STOP:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
    // The final STOP cycle counts as idle so consecutive frames have no gap.
    pop_vld = found && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
`ifdef MULTI_UPLOAD_TAG_EN
    tch_d = tch_q;
`endif
    if (pop_vld) begin
      byte_d = pop_byte;
      last_d = sel;
      bit_d  = 4'd0;
      baud_d = '0;
`ifdef MULTI_UPLOAD_TAG_EN
      tch_d   = sel;
      state_d = S_TAG;
`else
      state_d = S_START;
`endif
    end
    tx_d = 1'b1;
`ifdef MULTI_UPLOAD_TAG_EN
    tag_w   = 8'hA0 | 8'(tch_d);
    tag_idx = 3'(bit_d - 4'd1);
`endif
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_d[2:0]];
`ifdef MULTI_UPLOAD_TAG_EN
      S_TAG:   tx_d = (bit_d == 4'd0) ? 1'b0 : ((bit_d == 4'd9) ? 1'b1 : tag_w[tag_idx]);
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_24m) begin
    for (int n = 0; n < CH_NUM; n++) begin
      if (wr_en[n]) mem_q[n][wr_q[n]] <= shift_d[n];
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      {udi_s1_q, udi_s2_q, nvm_s1_q, nvm_s2_q} <= '0;
      {dclk_s1_q, dclk_s2_q, dclk_s3_q}        <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        shift_q[n] <= '0;
        bcnt_q[n]  <= '0;
        wr_q[n]    <= '0;
        rd_q[n]    <= '0;
        cnt_q[n]   <= '0;
      end
      ovf_q   <= '0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      last_q  <= SW'(CH_NUM - 1);
      tx_q    <= 1'b1;
`ifdef MULTI_UPLOAD_TAG_EN
      tch_q   <= '0;
`endif
    end else begin
      udi_s1_q  <= up_if.ch_udi;
      udi_s2_q  <= udi_s1_q;
      nvm_s1_q  <= up_if.ch_nvm;
      nvm_s2_q  <= nvm_s1_q;
      dclk_s1_q <= up_if.ch_dclk;
      dclk_s2_q <= dclk_s1_q;
      dclk_s3_q <= dclk_s2_q;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
`ifdef MULTI_UPLOAD_TAG_EN
      tch_q     <= tch_d;
`endif
    end
  end

  assign up_if.tx       = tx_q;
  assign up_if.busy     = (state_q != S_IDLE);
  assign up_if.ch_empty = ~nonempty;
  assign up_if.ch_ovf   = ovf_q;
endmodule

// File: tb/tb_multi_upload.sv
// Directed bench for multi_upload: a UART monitor pops an expected-byte queue filled as bytes are captured.
`timescale 1ns/1ps
module tb_multi_upload;
  localparam int CH = 2;
`ifdef MULTI_UPLOAD_TAG_EN
  localparam int BAUD  = 104;
  localparam int FRAME = 20;
`else
  localparam int BAUD  = 208;
  localparam int FRAME = 10;
`endif

  logic clk_24m = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_24m = ~clk_24m;

  multi_upload_if #(.CH_NUM(CH)) up_if ();

  multi_upload #(.CH_NUM(CH), .FIFO_DEPTH(16), .BAUD_DIV(BAUD)) dut (
    .clk_24m(clk_24m),
    .rst    (rst),
    .up_if  (up_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  bit abort = 1'b0;

  int cyc = 0, rise_cyc = 0, busy_len = 0, nfall = 0, ne0_cnt = 0;
  logic busy_p = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_24m) begin
    cyc    <= cyc + 1;
    busy_p <= up_if.busy;
    if (up_if.busy && !busy_p) rise_cyc <= cyc;
    if (!up_if.busy && busy_p) begin
      busy_len <= cyc - rise_cyc;
      nfall    <= nfall + 1;
    end
    if (!up_if.ch_empty[0]) ne0_cnt <= ne0_cnt + 1;
  end

  // UART monitor: samples mid-bit and checks each frame against the head of the queue.
  initial begin : mon
    logic [9:0] s;
    bit ab;
    forever begin
      @(negedge clk_24m);
      if (!rst && !abort && up_if.tx === 1'b0) begin
        chk("busy_at_start", up_if.busy, 1);
        ab = 1'b0;
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? BAUD / 2 : BAUD) @(negedge clk_24m);
          if (abort) ab = 1'b1;
          s[b] = up_if.tx;
        end
        if (!ab) begin
          chk("start_bit", s[0], 0);
          chk("stop_bit", s[9], 1);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_byte", s[8:1], exp_q.pop_front());
        end
      end
    end
  end

  task automatic exp_frame(input logic ch, input logic [7:0] b);
`ifdef MULTI_UPLOAD_TAG_EN
    exp_q.push_back(8'hA0 | {7'd0, ch});
`endif
    exp_q.push_back(b);
  endtask

  task automatic send_bits(input logic ch, input logic [7:0] b, input int n);
    logic [7:0] sh;
    sh = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_24m);
      up_if.ch_udi[ch]  = sh[7];
      up_if.ch_dclk[ch] = 1'b0;
      sh = sh << 1;
      repeat (3) @(negedge clk_24m);
      up_if.ch_dclk[ch] = 1'b1;
      repeat (3) @(negedge clk_24m);
    end
    up_if.ch_dclk[ch] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int nf0, input int limit, input int exp_len);
    for (int i = 0; i < limit && nfall == nf0; i++) @(negedge clk_24m);
    chk({tag, "_busy_fell"}, nfall != nf0, 1);
    chk({tag, "_busy_len"}, busy_len, exp_len);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int nf, ne, t0, lows;
    up_if.ch_udi  = '0;
    up_if.ch_nvm  = '0;
    up_if.ch_dclk = '0;
    up_if.ch_en   = '0;
    up_if.ovf_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_24m);
    chk("rst_tx", up_if.tx, 1);
    chk("rst_busy", up_if.busy, 0);
    chk("rst_empty", up_if.ch_empty, 2'b11);
    chk("rst_ovf", up_if.ch_ovf, 2'b00);
    rst = 1'b0;
    up_if.ch_en  = '1;
    up_if.ch_nvm = '1;
    repeat (4) @(negedge clk_24m);

    // single byte 0xA5 on ch0
    ne = ne0_cnt; nf = nfall;
    exp_frame(1'b0, 8'hA5);
    send_bits(1'b0, 8'hA5, 8);
    repeat (6) @(negedge clk_24m);
    chk("a5_empty_fell", ne0_cnt != ne, 1);
    wait_done("a5", nf, 2 * FRAME * BAUD, FRAME * BAUD);

    // single byte 0x5A on ch1
    nf = nfall;
    exp_frame(1'b1, 8'h5A);
    send_bits(1'b1, 8'h5A, 8);
    wait_done("5a", nf, 2 * FRAME * BAUD, FRAME * BAUD);

    // overflow: ch0 byte occupies tx while ch1 gets 17 bytes
    nf = nfall;
    exp_frame(1'b0, 8'h55);
    send_bits(1'b0, 8'h55, 8);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_frame(1'b1, 8'(8'h80 + i));
      send_bits(1'b1, 8'(8'h80 + i), 8);
      if (i == 15) begin
        repeat (6) @(negedge clk_24m);
        chk("ovf_before_17th", up_if.ch_ovf[1], 0);
        chk("ch1_not_empty", up_if.ch_empty[1], 0);
      end
    end
    repeat (6) @(negedge clk_24m);
    chk("ovf_set", up_if.ch_ovf[1], 1);
    chk("ovf_ch0_clear", up_if.ch_ovf[0], 0);
    up_if.ovf_clr = 1'b1;
    @(negedge clk_24m);
    up_if.ovf_clr = 1'b0;
    @(negedge clk_24m);
    chk("ovf_cleared", up_if.ch_ovf[1], 0);
    wait_done("ovf", nf, 18 * FRAME * BAUD, 17 * FRAME * BAUD);
    chk("ovf_all_empty", up_if.ch_empty, 2'b11);

    // round-robin interleave, back-to-back
    nf = nfall;
    exp_frame(1'b0, 8'h11);
    exp_frame(1'b1, 8'h21);
    exp_frame(1'b0, 8'h12);
    exp_frame(1'b1, 8'h22);
    send_bits(1'b0, 8'h11, 8);
    send_bits(1'b0, 8'h12, 8);
    send_bits(1'b1, 8'h21, 8);
    send_bits(1'b1, 8'h22, 8);
    wait_done("rr", nf, 5 * FRAME * BAUD, 4 * FRAME * BAUD);

    // partial byte discarded when nvm drops
    ne = ne0_cnt; nf = nfall;
    send_bits(1'b0, 8'hB0, 5);
    @(negedge clk_24m);
    up_if.ch_nvm[0] = 1'b0;
    repeat (6) @(negedge clk_24m);
    up_if.ch_nvm[0] = 1'b1;
    repeat (4) @(negedge clk_24m);
    chk("partial_dropped", ne0_cnt != ne, 0);
    exp_frame(1'b0, 8'h3C);
    send_bits(1'b0, 8'h3C, 8);
    wait_done("nvm", nf, 2 * FRAME * BAUD, FRAME * BAUD);

    // reset during data bit 3, with a second byte still queued
    send_bits(1'b0, 8'h0F, 8);
    t0 = -1;
    for (int i = 0; i < 100 && t0 < 0; i++) begin
      @(negedge clk_24m);
      if (up_if.tx === 1'b0) t0 = cyc;
    end
    chk("rst_test_frame_started", t0 >= 0, 1);
    send_bits(1'b0, 8'hF0, 8);
`ifdef MULTI_UPLOAD_TAG_EN
    t0 = t0 + 10 * BAUD;
`endif
    for (int i = 0; i < 20 * BAUD && cyc < t0 + 4 * BAUD + BAUD / 2; i++) @(negedge clk_24m);
    abort = 1'b1;
    rst   = 1'b1;
    #1;
    chk("midrst_tx", up_if.tx, 1);
    chk("midrst_busy", up_if.busy, 0);
    chk("midrst_empty", up_if.ch_empty, 2'b11);
    repeat (3) @(negedge clk_24m);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME * BAUD; i++) begin
      @(negedge clk_24m);
      if (up_if.tx !== 1'b1) lows++;
    end
    chk("no_frame_after_rst", lows, 0);
    chk("idle_after_rst", up_if.busy, 0);
    abort = 1'b0;
    chk("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
